// File: rtl/rs_wakeup_select_if.sv
// Bus interface for the reservation-station wakeup/select block.
// Carries the dispatch handshake, CDB broadcast, CAM table/hit exchange,
// flush and the issue handshake. The slave modport is the RS side; the
// master modport is the surrounding pipeline (dispatch, CDB, CAM and FU).
interface rs_wakeup_select_if #(
  parameter int LENGTH    = 16,
  parameter int WIDTH     = 2,
  parameter int NUM_TAGS  = 3,
  parameter int TAG_SIZE  = 6,
  parameter int PAYLOAD_W = 32
) ();

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic                                          flush;
  logic                                          dispatch_valid;
  logic                                          dispatch_ready;
  logic [WIDTH-1:0][TAG_SIZE-1:0]                dispatch_src_tag;
  logic [WIDTH-1:0]                              dispatch_src_rdy;
  logic [TAG_SIZE-1:0]                           dispatch_dest_tag;
  logic [PAYLOAD_W-1:0]                          dispatch_payload;
  logic [NUM_TAGS-1:0]                           cdb_valid;
  logic [NUM_TAGS-1:0][TAG_SIZE-1:0]             cdb_tag;
  logic [LENGTH-1:0][WIDTH-1:0][TAG_SIZE-1:0]    table_out;
  logic [LENGTH-1:0][WIDTH-1:0][NUM_TAGS-1:0]    cam_hits;
  logic                                          issue_valid;
  logic                                          issue_ready;
  logic [WIDTH-1:0][TAG_SIZE-1:0]                issue_src_tag;
  logic [TAG_SIZE-1:0]                           issue_dest_tag;
  logic [PAYLOAD_W-1:0]                          issue_payload;
  logic [IDX_W-1:0]                              issue_idx;

  modport slave (
    input  flush, dispatch_valid, dispatch_src_tag, dispatch_src_rdy,
           dispatch_dest_tag, dispatch_payload, cdb_valid, cdb_tag,
           cam_hits, issue_ready,
    output dispatch_ready, table_out, issue_valid, issue_src_tag,
           issue_dest_tag, issue_payload, issue_idx
  );

  modport master (
    output flush, dispatch_valid, dispatch_src_tag, dispatch_src_rdy,
           dispatch_dest_tag, dispatch_payload, cdb_valid, cdb_tag,
           cam_hits, issue_ready,
    input  dispatch_ready, table_out, issue_valid, issue_src_tag,
           issue_dest_tag, issue_payload, issue_idx
  );

endinterface

// File: rtl/rs_wakeup_select.sv
// Reservation-station entry store with CAM-driven wakeup and single issue
// select per cycle. Stored source tags go out on table_out to the external
// tag-match CAM; its hit matrix sets operand-ready bits. Dispatch writes the
// lowest free slot, with same-cycle CDB bypass on the source tags.
// Optional build macro RS_AGE_SELECT_EN: when defined, an age matrix picks the
// oldest eligible entry; otherwise the lowest-index eligible entry issues.
module rs_wakeup_select #(
  parameter int LENGTH    = 16,
  parameter int WIDTH     = 2,
  parameter int NUM_TAGS  = 3,
  parameter int TAG_SIZE  = 6,
  parameter int PAYLOAD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  rs_wakeup_select_if.slave bus
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic [LENGTH-1:0]                           valid;
  logic [LENGTH-1:0][WIDTH-1:0]                rdy;
  logic [LENGTH-1:0][WIDTH-1:0][TAG_SIZE-1:0]  src_tag;
  logic [LENGTH-1:0][TAG_SIZE-1:0]             dest_tag;
  logic [LENGTH-1:0][PAYLOAD_W-1:0]            payload;

  logic [LENGTH-1:0][WIDTH-1:0]                wake;
  logic [LENGTH-1:0]                           eligible;
  logic [LENGTH-1:0]                           free_oh;
  logic                                        free_found;
  logic [LENGTH-1:0]                           sel_oh;
  logic [WIDTH-1:0]                            byp_rdy;
  logic                                        dispatch_fire;
  logic                                        issue_fire;

  logic [WIDTH-1:0][TAG_SIZE-1:0]              sel_src;
  logic [TAG_SIZE-1:0]                         sel_dest;
  logic [PAYLOAD_W-1:0]                        sel_pay;
  logic [IDX_W-1:0]                            sel_idx;

  assign bus.dispatch_ready = ~(&valid);
  assign bus.issue_valid    = |eligible;
  assign bus.table_out      = src_tag;
  assign dispatch_fire      = bus.dispatch_valid & bus.dispatch_ready;
  assign issue_fire         = bus.issue_ready & bus.issue_valid;

  // Reduce CAM hits per operand and derive issue eligibility from registered state
  always_comb begin
    wake     = '0;
    eligible = '0;
    for (int i = 0; i < LENGTH; i++) begin
      for (int s = 0; s < WIDTH; s++) begin
        wake[i][s] = |bus.cam_hits[i][s];
      end
      eligible[i] = valid[i] & (&rdy[i]);
    end
  end

  // Lowest-index slot that is free at the start of the cycle
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      if (!valid[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  // Operands already ready or produced by this cycle's broadcasts
  always_comb begin
    byp_rdy = bus.dispatch_src_rdy;
    for (int s = 0; s < WIDTH; s++) begin
      for (int k = 0; k < NUM_TAGS; k++) begin
        if (bus.cdb_valid[k] && (bus.cdb_tag[k] == bus.dispatch_src_tag[s])) begin
          byp_rdy[s] = 1'b1;
        end
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  // older[j][i] set means entry j was dispatched before entry i
  logic [LENGTH-1:0][LENGTH-1:0] older;
  logic [LENGTH-1:0]             has_older;

  // Oldest-first select: eligible entry with no eligible older entry
  always_comb begin
    has_older = '0;
    for (int i = 0; i < LENGTH; i++) begin
      for (int j = 0; j < LENGTH; j++) begin
        if (eligible[j] && older[j][i]) begin
          has_older[i] = 1'b1;
        end
      end
    end
    sel_oh = eligible & ~has_older;
  end

  // Age matrix: new entry is younger than every currently valid entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      older <= '0;
    end else if (bus.flush) begin
      older <= '0;
    end else if (dispatch_fire) begin
      for (int i = 0; i < LENGTH; i++) begin
        if (free_oh[i]) begin
          for (int j = 0; j < LENGTH; j++) begin
            older[j][i] <= (j != i) ? valid[j] : 1'b0;
            older[i][j] <= 1'b0;
          end
        end
      end
    end
  end
`else
  logic sel_found;

  // Lowest-index eligible entry wins
  always_comb begin
    sel_oh    = '0;
    sel_found = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      if (eligible[i] && !sel_found) begin
        sel_oh[i] = 1'b1;
        sel_found = 1'b1;
      end
    end
  end
`endif

  // One-hot mux of the selected entry onto the issue outputs, zero when idle
  always_comb begin
    sel_src  = '0;
    sel_dest = '0;
    sel_pay  = '0;
    sel_idx  = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (sel_oh[i]) begin
        sel_src  = src_tag[i];
        sel_dest = dest_tag[i];
        sel_pay  = payload[i];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign bus.issue_src_tag  = sel_src;
  assign bus.issue_dest_tag = sel_dest;
  assign bus.issue_payload  = sel_pay;
  assign bus.issue_idx      = sel_idx;

  // Entry store: wakeup, issue release and dispatch write; flush squashes all
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid    <= '0;
      rdy      <= '0;
      src_tag  <= '0;
      dest_tag <= '0;
      payload  <= '0;
    end else if (bus.flush) begin
      valid <= '0;
      rdy   <= '0;
    end else begin
      for (int i = 0; i < LENGTH; i++) begin
        if (valid[i]) begin
          rdy[i] <= rdy[i] | wake[i];
        end
        if (issue_fire && sel_oh[i]) begin
          valid[i] <= 1'b0;
        end
        if (dispatch_fire && free_oh[i]) begin
          valid[i]    <= 1'b1;
          rdy[i]      <= byp_rdy;
          src_tag[i]  <= bus.dispatch_src_tag;
          dest_tag[i] <= bus.dispatch_dest_tag;
          payload[i]  <= bus.dispatch_payload;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Testbench for rs_wakeup_select: directed scenarios followed by randomized
// traffic, all checked against a per-entry behavioural model of the RS.
module tb_rs_wakeup_select;

  localparam int L = 16;
  localparam int W = 2;
  localparam int K = 3;
  localparam int T = 6;
  localparam int P = 32;

  logic clock;
  logic reset;

  rs_wakeup_select_if #(.LENGTH(L), .WIDTH(W), .NUM_TAGS(K), .TAG_SIZE(T), .PAYLOAD_W(P)) bus ();

  rs_wakeup_select #(.LENGTH(L), .WIDTH(W), .NUM_TAGS(K), .TAG_SIZE(T), .PAYLOAD_W(P)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;
  bit junk_en = 1'b0;

  // Reference model: one record per slot, age kept as a dispatch sequence number
  bit           m_valid [L];
  bit           m_rdy   [L][W];
  logic [T-1:0] m_tag   [L][W];
  logic [T-1:0] m_dest  [L];
  logic [P-1:0] m_pay   [L];
  int           m_seq   [L];
  int           seq_ctr = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_free();
    for (int i = 0; i < L; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int model_sel();
    int best = -1;
    for (int i = 0; i < L; i++) begin
      if (m_valid[i] && m_rdy[i][0] && m_rdy[i][1]) begin
`ifdef RS_AGE_SELECT_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  task automatic idle();
    bus.flush             = 1'b0;
    bus.dispatch_valid    = 1'b0;
    bus.dispatch_src_tag  = '0;
    bus.dispatch_src_rdy  = '0;
    bus.dispatch_dest_tag = '0;
    bus.dispatch_payload  = '0;
    bus.cdb_valid         = '0;
    bus.cdb_tag           = '0;
    bus.issue_ready       = 1'b0;
  endtask

  task automatic set_disp(input int t0, input int t1, input int r, input int d, input int p);
    bus.dispatch_valid      = 1'b1;
    bus.dispatch_src_tag[0] = T'(t0);
    bus.dispatch_src_tag[1] = T'(t1);
    bus.dispatch_src_rdy    = W'(r);
    bus.dispatch_dest_tag   = T'(d);
    bus.dispatch_payload    = P'(p);
  endtask

  task automatic set_cdb(input int v, input int t0, input int t1, input int t2);
    bus.cdb_valid  = K'(v);
    bus.cdb_tag[0] = T'(t0);
    bus.cdb_tag[1] = T'(t1);
    bus.cdb_tag[2] = T'(t2);
  endtask

  // Drive the CAM from the model's stored tags, compare outputs, advance one edge
  task automatic step();
    int sel;
    int fr;
    bit hits [L][W];
    bit byp;
    logic [L-1:0][W-1:0][T-1:0] exp_tab;
    logic [W-1:0][T-1:0]        exp_src;

    for (int i = 0; i < L; i++) begin
      for (int s = 0; s < W; s++) begin
        hits[i][s] = 1'b0;
        for (int k = 0; k < K; k++) begin
          bus.cam_hits[i][s][k] = (bus.cdb_valid[k] && bus.cdb_tag[k] == m_tag[i][s]) ||
                                  (junk_en && !m_valid[i] && $urandom_range(0, 3) == 0);
          if (bus.cam_hits[i][s][k]) hits[i][s] = 1'b1;
        end
        exp_tab[i][s] = m_tag[i][s];
      end
    end

    sel = model_sel();
    fr  = model_free();
    check_eq("dispatch_ready", 256'(bus.dispatch_ready), 256'(fr >= 0));
    check_eq("issue_valid", 256'(bus.issue_valid), 256'(sel >= 0));
    check_eq("table_out", 256'(bus.table_out), 256'(exp_tab));
    if (sel >= 0) begin
      exp_src[0] = m_tag[sel][0];
      exp_src[1] = m_tag[sel][1];
      check_eq("issue_idx", 256'(bus.issue_idx), 256'(sel));
      check_eq("issue_dest_tag", 256'(bus.issue_dest_tag), 256'(m_dest[sel]));
      check_eq("issue_payload", 256'(bus.issue_payload), 256'(m_pay[sel]));
      check_eq("issue_src_tag", 256'(bus.issue_src_tag), 256'(exp_src));
    end

    @(posedge clock);
    #1;
    if (bus.flush) begin
      for (int i = 0; i < L; i++) begin
        m_valid[i] = 1'b0;
        for (int s = 0; s < W; s++) m_rdy[i][s] = 1'b0;
      end
    end else begin
      for (int i = 0; i < L; i++)
        if (m_valid[i])
          for (int s = 0; s < W; s++) if (hits[i][s]) m_rdy[i][s] = 1'b1;
      if (sel >= 0 && bus.issue_ready) m_valid[sel] = 1'b0;
      if (bus.dispatch_valid && fr >= 0) begin
        m_valid[fr] = 1'b1;
        for (int s = 0; s < W; s++) begin
          byp = bus.dispatch_src_rdy[s];
          for (int k = 0; k < K; k++)
            if (bus.cdb_valid[k] && bus.cdb_tag[k] == bus.dispatch_src_tag[s]) byp = 1'b1;
          m_rdy[fr][s] = byp;
          m_tag[fr][s] = bus.dispatch_src_tag[s];
        end
        m_dest[fr] = bus.dispatch_dest_tag;
        m_pay[fr]  = bus.dispatch_payload;
        m_seq[fr]  = seq_ctr;
        seq_ctr++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < L; i++) begin
      m_valid[i] = 1'b0;
      m_dest[i]  = '0;
      m_pay[i]   = '0;
      m_seq[i]   = 0;
      for (int s = 0; s < W; s++) begin
        m_rdy[i][s] = 1'b0;
        m_tag[i][s] = '0;
      end
    end
    idle();
    bus.cam_hits = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_dispatch_ready", 256'(bus.dispatch_ready), 256'(1));
    check_eq("rst_issue_valid", 256'(bus.issue_valid), 256'(0));
    check_eq("rst_issue_idx", 256'(bus.issue_idx), 256'(0));
    check_eq("rst_issue_dest", 256'(bus.issue_dest_tag), 256'(0));
    check_eq("rst_issue_payload", 256'(bus.issue_payload), 256'(0));
    check_eq("rst_issue_src", 256'(bus.issue_src_tag), 256'(0));
    check_eq("rst_table_out", 256'(bus.table_out), 256'(0));
    reset = 1'b0;

    // Two-step CAM wakeup of entry 0
    set_disp(5, 7, 0, 9, 32'h1111); step();
    idle(); set_cdb(3'b001, 5, 0, 0); step();
    check_eq("t1_half_ready", 256'(bus.issue_valid), 256'(0));
    idle(); set_cdb(3'b010, 0, 7, 0); step();
    check_eq("t1_issue_valid", 256'(bus.issue_valid), 256'(1));
    check_eq("t1_issue_idx", 256'(bus.issue_idx), 256'(0));
    check_eq("t1_issue_dest", 256'(bus.issue_dest_tag), 256'(9));
    idle(); bus.issue_ready = 1'b1; step();
    check_eq("t1_drained", 256'(bus.issue_valid), 256'(0));

    // Dispatch bypass from same-cycle broadcast
    idle(); set_disp(3, 4, 0, 10, 32'h2222); set_cdb(3'b011, 3, 4, 0); step();
    check_eq("t2_bypass_valid", 256'(bus.issue_valid), 256'(1));
    check_eq("t2_bypass_dest", 256'(bus.issue_dest_tag), 256'(10));
    idle(); bus.issue_ready = 1'b1; step();

    // Fill, drop when full, free one slot
    for (int i = 0; i < L; i++) begin
      idle(); set_disp(i, i + 16, 0, i, i + 100); step();
    end
    check_eq("t3_full", 256'(bus.dispatch_ready), 256'(0));
    idle(); set_disp(60, 61, 3, 63, 32'hdead); step();
    check_eq("t3_drop_ready", 256'(bus.dispatch_ready), 256'(0));
    check_eq("t3_drop_noissue", 256'(bus.issue_valid), 256'(0));
    idle(); set_cdb(3'b011, 3, 19, 0); step();
    check_eq("t3_wake_idx", 256'(bus.issue_idx), 256'(3));
    idle(); bus.issue_ready = 1'b1; set_disp(60, 61, 3, 63, 32'hbeef); step();
    check_eq("t3_freed", 256'(bus.dispatch_ready), 256'(1));
    idle(); bus.flush = 1'b1; step();

    // Two entries ready together; slot 2 reused so entry 5 is older
    for (int i = 0; i < 6; i++) begin
      idle(); set_disp(20 + i, 30 + i, 0, i, i + 200); step();
    end
    idle(); set_cdb(3'b011, 22, 32, 0); step();
    check_eq("t4_first_idx", 256'(bus.issue_idx), 256'(2));
    idle(); bus.issue_ready = 1'b1; step();
    idle(); set_disp(50, 51, 0, 40, 32'h4040); step();
    idle(); set_cdb(3'b011, 50, 25, 0); step();
    idle(); set_cdb(3'b011, 51, 35, 0); step();
    check_eq("t4_pair_valid", 256'(bus.issue_valid), 256'(1));
`ifdef RS_AGE_SELECT_EN
    check_eq("t4_pick_a", 256'(bus.issue_idx), 256'(5));
`else
    check_eq("t4_pick_a", 256'(bus.issue_idx), 256'(2));
`endif
    idle(); bus.issue_ready = 1'b1; step();
`ifdef RS_AGE_SELECT_EN
    check_eq("t4_pick_b", 256'(bus.issue_idx), 256'(2));
`else
    check_eq("t4_pick_b", 256'(bus.issue_idx), 256'(5));
`endif
    idle(); bus.issue_ready = 1'b1; step();
    idle(); bus.flush = 1'b1; step();

    // Backpressure: entry held while issue_ready is low
    idle(); set_disp(1, 2, 3, 33, 32'h3333); step();
    for (int c = 0; c < 3; c++) begin
      check_eq("t5_hold_valid", 256'(bus.issue_valid), 256'(1));
      check_eq("t5_hold_idx", 256'(bus.issue_idx), 256'(0));
      idle(); step();
    end
    idle(); bus.issue_ready = 1'b1; step();
    check_eq("t5_released", 256'(bus.issue_valid), 256'(0));

    // Flush overrides same-cycle dispatch and issue
    for (int i = 0; i < 4; i++) begin
      idle(); set_disp(i + 8, i + 9, (i == 1) ? 3 : 0, i, i); step();
    end
    check_eq("t6_preflush_valid", 256'(bus.issue_valid), 256'(1));
    idle(); bus.flush = 1'b1; bus.issue_ready = 1'b1; set_disp(1, 1, 3, 7, 7); step();
    check_eq("t6_ready", 256'(bus.dispatch_ready), 256'(1));
    check_eq("t6_issue_valid", 256'(bus.issue_valid), 256'(0));
    idle(); step();
    check_eq("t6_empty", 256'(bus.issue_valid), 256'(0));

    // Randomized traffic with spurious hits on invalid slots
    junk_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      bus.flush             = ($urandom_range(0, 99) == 0);
      bus.dispatch_valid    = ($urandom_range(0, 9) < 6);
      bus.dispatch_src_tag[0] = T'($urandom_range(0, 15));
      bus.dispatch_src_tag[1] = T'($urandom_range(0, 15));
      bus.dispatch_src_rdy[0] = ($urandom_range(0, 9) == 0);
      bus.dispatch_src_rdy[1] = ($urandom_range(0, 9) == 0);
      bus.dispatch_dest_tag = T'($urandom_range(0, 63));
      bus.dispatch_payload  = P'($urandom);
      for (int k = 0; k < K; k++) begin
        bus.cdb_valid[k] = ($urandom_range(0, 1) == 1);
        bus.cdb_tag[k]   = T'($urandom_range(0, 15));
      end
      bus.issue_ready = ($urandom_range(0, 9) < 5);
      step();
    end
    junk_en = 1'b0;
    idle(); bus.flush = 1'b1; step();
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
